// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the multiplier job sequencer.
// Holds the FSM state encoding, the queued job payload and the default
// width, FIFO depth and WAIT timeout used by mul_job_sequencer.
package mul_seq_pkg;

  localparam int unsigned MUL_SEQ_W           = 16;
  localparam int unsigned MUL_SEQ_DEPTH       = 4;
  localparam int unsigned MUL_SEQ_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LD_A,
    LD_B,
    WAIT,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic [MUL_SEQ_W-1:0] a;
    logic [MUL_SEQ_W-1:0] b;
  } mul_job_t;

  // A zero operand makes the product trivially zero, so the multiplier is skipped.
  function automatic logic is_zero_job(input mul_job_t job);
    return (job.a == '0) || (job.b == '0);
  endfunction

endpackage

// File: rtl/mul_seq_fifo.sv
// Job queue for the multiplier sequencer.
// DEPTH-entry synchronous FIFO of mul_job_t with show-ahead read data.
// Pointers carry an extra wrap bit so full and empty come straight from them.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data push a job (ignored while full)
//   full           no free entry
//   rd_en          pop the head entry (ignored while empty)
//   rd_data        current head entry
//   empty          no entry held
module mul_seq_fifo
  import mul_seq_pkg::*;
#(
  parameter int unsigned DEPTH = MUL_SEQ_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  mul_job_t wr_data,
  output logic     full,
  input  logic     rd_en,
  output mul_job_t rd_data,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  mul_job_t      mem [DEPTH];

  logic do_wr;
  logic do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mul_job_sequencer.sv
// Upstream feeder for the 16-bit repeated-addition multiplier.
// Queues operand pairs, starts the multiplier, presents A then B on the
// shared operand bus, waits for done, returns the product and re-arms the
// multiplier with a one-cycle mul_clr pulse. Jobs with a zero operand are
// answered directly with 0 and never reach the multiplier.
// Optional feature macro: MUL_SEQ_TIMEOUT_EN -- bounds the WAIT state to
// TIMEOUT_CYC cycles and reports a timeout through res_err.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   job_valid/job_ready/job_a/b   operand pair input handshake
//   start, data_bus               multiplier start pulse and operand bus
//   done, prod                    multiplier completion level and product
//   mul_clr                       pulse returning the multiplier to idle
//   res_valid/res_ready           result handshake
//   res_data, res_err             product (mod 2^W) and timeout flag
module mul_job_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned W           = MUL_SEQ_W,
  parameter int unsigned DEPTH       = MUL_SEQ_DEPTH,
  parameter int unsigned TIMEOUT_CYC = MUL_SEQ_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [W-1:0] job_a,
  input  logic [W-1:0] job_b,
  output logic         start,
  output logic [W-1:0] data_bus,
  input  logic         done,
  input  logic [W-1:0] prod,
  output logic         mul_clr,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  seq_state_t   state_q;
  seq_state_t   state_d;
  mul_job_t     job_q;
  mul_job_t     job_d;
  mul_job_t     wr_job;
  mul_job_t     head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop_c;
  logic         timeout_c;
  logic         start_d;
  logic         mul_clr_d;
  logic         res_valid_d;
  logic         res_err_d;
  logic [W-1:0] data_bus_d;
  logic [W-1:0] res_data_d;

  assign wr_job.a  = job_a;
  assign wr_job.b  = job_b;
  assign job_ready = !fifo_full;

  mul_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (job_valid),
    .wr_data (wr_job),
    .full    (fifo_full),
    .rd_en   (pop_c),
    .rd_data (head),
    .empty   (fifo_empty)
  );

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] timer;

  // WAIT-cycle counter; cleared in LD_B so the first WAIT cycle sees 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_q == LD_B) begin
      timer <= '0;
    end else if (state_q == WAIT) begin
      timer <= timer + TW'(1);
    end
  end

  assign timeout_c = (timer == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and next registered output values
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    pop_c       = 1'b0;
    start_d     = 1'b0;
    mul_clr_d   = 1'b0;
    res_valid_d = 1'b0;
    data_bus_d  = '0;
    res_data_d  = res_data;
    res_err_d   = res_err;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          job_d = head;
          if (is_zero_job(head)) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            mul_clr_d   = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b0;
          end else begin
            state_d    = START;
            start_d    = 1'b1;
            data_bus_d = head.a;
          end
        end
      end
      START: begin
        state_d    = LD_A;
        data_bus_d = job_q.a;
      end
      LD_A: begin
        state_d    = LD_B;
        data_bus_d = job_q.b;
      end
      LD_B: begin
        state_d    = WAIT;
        data_bus_d = job_q.b;
      end
      WAIT: begin
        data_bus_d = job_q.b;
        // done takes priority over a timeout landing in the same cycle
        if (done) begin
          state_d     = RESP;
          res_valid_d = 1'b1;
          mul_clr_d   = 1'b1;
          res_data_d  = prod;
          res_err_d   = 1'b0;
        end else if (timeout_c) begin
          state_d     = RESP;
          res_valid_d = 1'b1;
          mul_clr_d   = 1'b1;
          res_data_d  = '0;
          res_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      job_q     <= '0;
      start     <= 1'b0;
      data_bus  <= '0;
      mul_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      start     <= start_d;
      data_bus  <= data_bus_d;
      mul_clr   <= mul_clr_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_err   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Self-checking bench for mul_job_sequencer with a behavioural multiplier.
// Build with or without MUL_SEQ_TIMEOUT_EN; the final scenario adapts.
`timescale 1ns/1ps
module tb_mul_job_sequencer;

  localparam int unsigned W    = 16;
  localparam int unsigned MDLY = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [W-1:0] job_a;
  logic [W-1:0] job_b;
  logic         start;
  logic [W-1:0] data_bus;
  logic         done;
  logic [W-1:0] prod;
  logic         mul_clr;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  always #5 clk = ~clk;

  mul_job_sequencer #(
    .W           (W),
    .DEPTH       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_a     (job_a),
    .job_b     (job_b),
    .start     (start),
    .data_bus  (data_bus),
    .done      (done),
    .prod      (prod),
    .mul_clr   (mul_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  // Behavioural multiplier: samples A, A, B on the bus after start, then
  // raises done MDLY cycles later and holds it until mul_clr.
  logic         mul_en;
  logic         done_force;
  logic         model_done;
  logic [W-1:0] ma;
  logic [W-1:0] ma2;
  logic [W-1:0] mb;
  int           m_st;
  int           m_cnt;
  int           start_cnt = 0;
  int           clr_cnt   = 0;

  assign done = model_done | done_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st       <= 0;
      m_cnt      <= 0;
      model_done <= 1'b0;
      prod       <= '0;
      ma         <= '0;
      ma2        <= '0;
      mb         <= '0;
    end else begin
      case (m_st)
        0: if (start && mul_en) begin ma <= data_bus; m_st <= 1; end
        1: begin ma2 <= data_bus; m_st <= 2; end
        2: begin mb <= data_bus; m_cnt <= MDLY; m_st <= 3; end
        3: begin
          if (m_cnt == 0) begin
            model_done <= 1'b1;
            prod       <= W'(32'(ma) * 32'(mb));
            m_st       <= 4;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: ;
      endcase
      if (mul_clr) begin
        m_st       <= 0;
        model_done <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (start)   start_cnt <= start_cnt + 1;
    if (mul_clr) clr_cnt   <= clr_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!job_ready && n < 50) begin tick(); n++; end
    chk($sformatf("push_ready_%0h_%0h", a, b), 32'(job_ready), 32'd1);
    job_valid = 1'b1;
    job_a     = a;
    job_b     = b;
    tick();
    job_valid = 1'b0;
  endtask

  // Wait for a result, optionally stall it, check it and complete the handshake.
  task automatic get_result(input string name, input logic [W-1:0] exp_d,
                            input logic exp_e, input int stall);
    int n = 0;
    res_ready = (stall == 0);
    while (!res_valid && n < 300) begin tick(); n++; end
    if (!res_valid) begin
      chk({name, "_valid_timeout"}, 32'(res_valid), 32'd1);
    end else begin
      for (int i = 0; i < stall; i++) begin
        tick();
        chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_hold_data"}, 32'(res_data), 32'(exp_d));
      end
      res_ready = 1'b1;
      chk({name, "_data"}, 32'(res_data), 32'(exp_d));
      chk({name, "_err"}, 32'(res_err), 32'(exp_e));
      tick();
      chk({name, "_released"}, 32'(res_valid), 32'd0);
    end
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    int c0;
    int n;
    logic seen;

    vecs[0] = '{a: 16'd1,      b: 16'd1,  res: 16'h0001, stall: 0};
    vecs[1] = '{a: 16'hFFFF,   b: 16'd2,  res: 16'hFFFE, stall: 1};
    vecs[2] = '{a: 16'd1000,   b: 16'd70, res: 16'h1170, stall: 0};
    vecs[3] = '{a: 16'd0,      b: 16'd0,  res: 16'h0000, stall: 2};
    vecs[4] = '{a: 16'hFFFF,   b: 16'd0,  res: 16'h0000, stall: 0};
    vecs[5] = '{a: 16'd123,    b: 16'd45, res: 16'd5535, stall: 1};

    rst = 1'b1; job_valid = 1'b0; job_a = '0; job_b = '0;
    res_ready = 1'b0; mul_en = 1'b1; done_force = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_bus", 32'(data_bus), 32'd0);
    chk("rst_clr", 32'(mul_clr), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single job 7*5 with cycle-level sequencing
    s0 = start_cnt; c0 = clr_cnt;
    push(16'd7, 16'd5);
    tick();
    chk("j75_start", 32'(start), 32'd1);
    chk("j75_bus_start", 32'(data_bus), 32'd7);
    tick();
    chk("j75_start_low", 32'(start), 32'd0);
    chk("j75_bus_lda", 32'(data_bus), 32'd7);
    tick();
    chk("j75_bus_ldb", 32'(data_bus), 32'd5);
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("j75_done_seen", 32'(done), 32'd1);
    chk("j75_bus_wait", 32'(data_bus), 32'd5);
    chk("j75_valid_before", 32'(res_valid), 32'd0);
    tick();
    chk("j75_valid", 32'(res_valid), 32'd1);
    chk("j75_clr_first", 32'(mul_clr), 32'd1);
    chk("j75_data", 32'(res_data), 32'd35);
    chk("j75_err", 32'(res_err), 32'd0);
    tick();
    chk("j75_clr_once", 32'(mul_clr), 32'd0);
    chk("j75_valid_held", 32'(res_valid), 32'd1);
    get_result("j75", 16'd35, 1'b0, 0);
    chk("j75_start_count", 32'(start_cnt - s0), 32'd1);
    chk("j75_clr_count", 32'(clr_cnt - c0), 32'd1);
    chk("j75_model_a", 32'(ma), 32'd7);
    chk("j75_model_a2", 32'(ma2), 32'd7);
    chk("j75_model_b", 32'(mb), 32'd5);

    // Zero bypass 9*0: result one cycle after pop, no start
    s0 = start_cnt;
    push(16'd9, 16'd0);
    tick();
    chk("bp90_valid", 32'(res_valid), 32'd1);
    chk("bp90_data", 32'(res_data), 32'd0);
    get_result("bp90", 16'd0, 1'b0, 0);
    chk("bp90_no_start", 32'(start_cnt - s0), 32'd0);

    // done outside WAIT is ignored
    done_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_done_valid", 32'(res_valid), 32'd0);
    end
    done_force = 1'b0;
    tick();

    // Bypass 0*3 held unaccepted while the FIFO fills behind it
    s0 = start_cnt;
    push(16'd0, 16'd3);
    tick();
    chk("bp03_valid", 32'(res_valid), 32'd1);
    chk("bp03_data", 32'(res_data), 32'd0);
    push(16'd3, 16'd4);
    chk("fill1_ready", 32'(job_ready), 32'd1);
    push(16'd2, 16'd8);
    push(16'd255, 16'd255);
    chk("fill3_ready", 32'(job_ready), 32'd1);
    push(16'd300, 16'd300);
    chk("fill4_full", 32'(job_ready), 32'd0);
    tick(); tick();
    chk("fill_still_full", 32'(job_ready), 32'd0);
    chk("bp03_held", 32'(res_valid), 32'd1);
    chk("bp03_no_start", 32'(start_cnt - s0), 32'd0);
    get_result("bp03", 16'd0, 1'b0, 2);
    tick();
    chk("fill_ready_after_pop", 32'(job_ready), 32'd1);
    get_result("f3x4", 16'd12, 1'b0, 2);
    get_result("f2x8", 16'd16, 1'b0, 2);
    get_result("f255", 16'hFE01, 1'b0, 2);
    get_result("f300", 16'h5F90, 1'b0, 2);

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b);
      get_result($sformatf("vec%0d", i), vecs[i].res, 1'b0, vecs[i].stall);
    end

    // Async reset during WAIT of 6*6
    push(16'd6, 16'd6);
    for (int i = 0; i < 5; i++) tick();
    chk("r66_bus_b_before", 32'(data_bus), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("r66_start", 32'(start), 32'd0);
    chk("r66_bus", 32'(data_bus), 32'd0);
    chk("r66_clr", 32'(mul_clr), 32'd0);
    chk("r66_valid", 32'(res_valid), 32'd0);
    chk("r66_data", 32'(res_data), 32'd0);
    chk("r66_err", 32'(res_err), 32'd0);
    chk("r66_job_ready", 32'(job_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    s0 = start_cnt;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("r66_fifo_empty_no_result", 32'(seen), 32'd0);
    chk("r66_fifo_empty_no_start", 32'(start_cnt - s0), 32'd0);
    push(16'd2, 16'd3);
    get_result("r23", 16'd6, 1'b0, 0);

    // Multiplier never answers
    mul_en = 1'b0;
    push(16'd4, 16'd4);
    n = 0;
    while (!start && n < 20) begin tick(); n++; end
    chk("tmo_start_seen", 32'(start), 32'd1);
`ifdef MUL_SEQ_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("tmo_latency", 32'(n), 32'd19);
    chk("tmo_clr", 32'(mul_clr), 32'd1);
    get_result("tmo", 16'd0, 1'b1, 0);
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("no_tmo_no_result", 32'(seen), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
